// File: rtl/ik_swift_st_pkg.sv
// rtl/ik_swift_st_pkg.sv - shared states, defaults and round-robin helper for swift stream blocks
//
// Purpose: common definitions for the swift Avalon-ST byte path.
//   st_state_t / ST_IDLE / ST_GRANT : arbiter FSM encoding
//   ST_DEF_*                        : default parameter values
//   rr_pick()                       : round-robin pick starting after 'last'
// Ports: none (package).

package ik_swift_st_pkg;

   localparam int unsigned ST_DEF_NUM_IN    = 2;
   localparam int unsigned ST_DEF_DATA_W    = 8;
   localparam int unsigned ST_DEF_MAX_BURST = 16;

   // Widest requester vector rr_pick understands; callers zero-pad to this.
   localparam int unsigned ST_MAX_IN = 8;

   typedef logic [0:0] st_state_t;

   localparam st_state_t ST_IDLE  = 1'b0;
   localparam st_state_t ST_GRANT = 1'b1;

   // Returns the first asserted request scanning last+1, last+2, ... modulo
   // num_in. With no request set, 'last' is returned unchanged.
   function automatic int unsigned rr_pick(
      input logic [ST_MAX_IN-1:0] req,
      input int unsigned          last,
      input int unsigned          num_in
   );
      int unsigned pick;
      logic        found;
      logic [2:0]  idx;
      pick  = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= ST_MAX_IN; i++) begin
         idx = 3'((last + i) % num_in);
         if (!found && (i <= num_in) && req[idx]) begin
            pick  = 32'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/ik_swift_st_out_reg.sv
// rtl/ik_swift_st_out_reg.sv - one-entry registered ready/valid output stage
//
// Purpose: holds one beat (data, eop, channel) toward a ready/valid sink.
//   A load and a drain in the same cycle keep out_valid high with the new beat.
//   Contents stay stable while out_valid && !out_ready.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture load_* this cycle (only legal when load_ready)
//   load_data/eop/channel : beat to capture
//   load_ready      : stage can accept a beat this cycle
//   out_valid/data/eop/channel : registered beat toward the sink
//   out_ready       : sink ready

module ik_swift_st_out_reg #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CH_W   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_eop,
   input  logic [CH_W-1:0]   load_channel,
   output logic              load_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_eop,
   output logic [CH_W-1:0]   out_channel,
   input  logic              out_ready
);

   // Empty, or the held beat leaves this cycle.
   assign load_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_eop     <= 1'b0;
         out_channel <= '0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_data    <= load_data;
         out_eop     <= load_eop;
         out_channel <= load_channel;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/ik_swift_st_byte_arbiter.sv
// rtl/ik_swift_st_byte_arbiter.sv - packet-aware round-robin arbiter onto one byte stream
//
// Purpose: shares one Avalon-ST byte sink between NUM_IN sources. A grant is
//   held until end-of-packet or MAX_BURST bytes, then rotates onward.
//   One idle arbitration cycle separates grants.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   in_valid     : per-source valid
//   in_data      : source i at [i*DATA_W +: DATA_W]
//   in_eop       : per-source end-of-packet
//   in_ready     : per-source ready, at most one bit high
//   out_valid/out_data/out_eop/out_channel : registered output beat
//   out_ready    : sink ready

module ik_swift_st_byte_arbiter
   import ik_swift_st_pkg::*;
#(
   parameter int unsigned NUM_IN    = ST_DEF_NUM_IN,
   parameter int unsigned DATA_W    = ST_DEF_DATA_W,
   parameter int unsigned MAX_BURST = ST_DEF_MAX_BURST
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_IN-1:0]          in_valid,
   input  logic [NUM_IN*DATA_W-1:0]   in_data,
   input  logic [NUM_IN-1:0]          in_eop,
   output logic [NUM_IN-1:0]          in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_eop,
   output logic [$clog2(NUM_IN)-1:0]  out_channel,
   input  logic                       out_ready
);

   localparam int unsigned CH_W = $clog2(NUM_IN);
   localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

   st_state_t             state;
   logic [CH_W-1:0]       gnt;
   logic [CH_W-1:0]       last;
   logic [BC_W-1:0]       burst_cnt;

   logic [ST_MAX_IN-1:0]  req_pad;
   logic [CH_W-1:0]       next_gnt;
   logic                  gnt_valid;
   logic                  gnt_eop;
   logic [DATA_W-1:0]     gnt_data;
   logic                  load_ready;
   logic                  xfer;
   logic                  release_gnt;

   always_comb begin
      req_pad = '0;
      req_pad[NUM_IN-1:0] = in_valid;
   end

   assign next_gnt = CH_W'(rr_pick(req_pad, 32'(last), NUM_IN));

   // Granted-source mux, written with constant indices so it stays clean
   // for NUM_IN values that are not a power of two.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_eop   = 1'b0;
      gnt_data  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gnt == CH_W'(i)) begin
            gnt_valid = in_valid[i];
            gnt_eop   = in_eop[i];
            gnt_data  = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Ready never looks at in_valid, so a source may wait on it safely.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_ready[i] = (state == ST_GRANT) && (gnt == CH_W'(i)) && load_ready;
      end
   end

   assign xfer        = (state == ST_GRANT) && gnt_valid && load_ready;
   // Burst-limit release may split a packet; the rest resumes on a later grant.
   assign release_gnt = xfer && (gnt_eop || (burst_cnt == BC_W'(MAX_BURST - 1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         last      <= CH_W'(NUM_IN - 1);
         burst_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|in_valid) begin
                  gnt       <= next_gnt;
                  burst_cnt <= '0;
                  state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (xfer) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
               if (release_gnt) begin
                  last  <= gnt;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   ik_swift_st_out_reg #(
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) u_out_reg (
      .clk          (clk),
      .reset        (reset),
      .load         (xfer),
      .load_data    (gnt_data),
      .load_eop     (gnt_eop),
      .load_channel (gnt),
      .load_ready   (load_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_eop      (out_eop),
      .out_channel  (out_channel),
      .out_ready    (out_ready)
   );

endmodule

// File: doc/ik_swift_st_byte_arbiter.md
# ik_swift_st_byte_arbiter

Round-robin, packet-aware arbiter that shares one 8-bit Avalon-ST byte sink, the host-side timing-adapter stream of the qsys master, between `NUM_IN` byte sources.
- A grant is held until end-of-packet or a burst limit, then rotates to the next requester.
- Output goes through a single registered stage that honours `out_ready` backpressure.
- It sits between the command sources and the timing adapter, and is the only driver of that adapter's input.

## Interface
Parameters:
- `NUM_IN`, default 2: number of requesting sources, 2..8.
- `DATA_W`, default 8: payload width per source.
- `MAX_BURST`, default 16: maximum bytes per grant, 1..256.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  NUM_IN  per-source valid.
- `in_data`  in  NUM_IN*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- `in_eop`  in  NUM_IN  per-source end-of-packet.
- `in_ready`  out  NUM_IN  per-source ready; at most one bit high.
- `out_valid`  out  1  registered output valid.
- `out_data`  out  DATA_W  registered output byte.
- `out_eop`  out  1  registered end-of-packet.
- `out_channel`  out  clog2(NUM_IN)  index of the source of the current output byte.
- `out_ready`  in  1  sink ready.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: source `gnt` owns the output.
- IDLE: if any `in_valid` is set, pick the first asserted source scanning from `last+1` upward, modulo NUM_IN. Load `gnt`, clear `burst_cnt`, go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - `in_ready[gnt] = !out_valid || out_ready`; all other `in_ready` bits are 0.
  - Transfer: `in_valid[gnt] && in_ready[gnt]`. On each transfer, register data, eop and `gnt` into the output stage, set `out_valid`, and increment `burst_cnt`.
  - Grant release happens on a transfer with `in_eop=1`, or on a transfer with `burst_cnt == MAX_BURST-1`. On release, set `last <= gnt` and go to IDLE.
  - If `in_valid[gnt]` drops mid-packet, the grant is held with no timeout.
- Output stage: `out_valid` clears on `out_ready && out_valid` when no new transfer occurs in the same cycle. A simultaneous drain and load keeps `out_valid=1` with the new byte.
- `burst_cnt` width is clog2(MAX_BURST+1). It never wraps, because release occurs at MAX_BURST-1.
- The burst limit can split a packet. The remainder resumes on a later grant with `out_eop` only at the true eop.
- Reset values:
  - state IDLE.
  - `last = NUM_IN-1`, so source 0 wins first.
  - `burst_cnt = 0`.
  - `out_valid = 0`, `out_data = 0`, `out_eop = 0`, `out_channel = 0`.
  - `in_ready` all 0.
- Reset mid-packet drops any held output byte and the grant; no partial-packet recovery.

## Timing
- Arbitration costs exactly 1 cycle in IDLE; `in_ready` is never high in IDLE.
- Latency from input transfer to `out_valid` is 1 cycle.
- Throughput is 1 byte/cycle within a grant when `out_ready=1`. Each grant costs one extra bubble cycle.
- `in_ready` depends combinationally on `out_ready`, `out_valid` and state. It has no dependence on `in_valid`.
- `out_*` hold stable while `out_valid && !out_ready`, per Avalon-ST.
- Simultaneous requests from all sources are served in strict rotation. No source waits more than NUM_IN-1 grants.

## Structure
- Package `ik_swift_st_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_GRANT`).
  - `function rr_pick(req, last)` returning the next index.
  - Constants for default widths.
- Sub-module `ik_swift_st_out_reg`: the one-entry registered output stage with ready/valid. It is reusable by other stream blocks.
- Top level holds the FSM, `gnt`/`last`/`burst_cnt` and the input muxing.

## Test plan
- Single source: source 0 sends a 3-byte packet 0x11,0x22,0x33 (eop on 0x33) with `out_ready=1`.
  - `in_ready[0]` rises in cycle 1 after request.
  - Output shows 0x11,0x22,0x33 on consecutive cycles with `out_channel=0`, `out_eop` on the third byte.
- Contention: sources 0 and 1 both hold 2-byte packets after reset.
  - Order is source 0 packet, one bubble cycle, then source 1 packet.
  - Repeating the test yields 0 then 1 again, because `last` rotated.
- Burst split: MAX_BURST=4, source 1 sends a 6-byte packet while source 0 also requests.
  - Sequence is 4 bytes of ch1 with `out_eop=0`, then ch0's packet, then the 2 remaining ch1 bytes with eop on the last.
- Backpressure: `out_ready=0` for 5 cycles mid-packet.
  - `out_data` stays stable and `in_ready[gnt]=0`.
  - No byte is lost or duplicated after `out_ready` returns to 1.
- Mid-packet reset: `reset` is asserted after byte 2 of 5.
  - Next cycle: `out_valid=0` and `in_ready=0`.
  - After release, source 0 is granted first.
- Valid gap: the granted source drops `in_valid` for 3 cycles mid-packet while source 1 requests.
  - The grant is retained and source 1 is not served until the eop.
